// File: rtl/snn_ctrl.sv
// snn_ctrl: unpacks a 98-byte binary image into the input-unit RAM, runs the SNN core
// and reports the classified digit on the LEDs and as an ASCII byte over the UART.
module snn_ctrl #(
    parameter int NUM_BYTES = 98,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_d,
    input  logic [ADDR_W-1:0] core_addr,
    output logic              snn_start,
    input  logic              snn_done,
    input  logic [3:0]        digit,
    output logic [7:0]        led,
    output logic              busy,
    output logic              overrun
);
    typedef enum logic [2:0] {IDLE, UNPACK, START, WAIT_DONE, TX} state_t;
    localparam int BW = ADDR_W - 3;

    state_t        state_q, state_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d, pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d, overrun_q, overrun_d;
    logic [3:0]    digit_q, digit_d;
    logic          last_bit, last_byte, consume, store;

    assign last_bit  = bit_cnt_q == 3'd7;
    assign last_byte = byte_cnt_q == BW'(NUM_BYTES - 1);
    // The pending byte re-enters the load phase from IDLE or straight from the end of a byte.
    assign consume   = pend_vld_q && (state_q == IDLE || (state_q == UNPACK && last_bit && !last_byte));
    assign store     = rx_rdy && !(state_q == IDLE && !pend_vld_q);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        digit_d    = digit_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        overrun_d  = overrun_q;
        case (state_q)
            IDLE: if (pend_vld_q || rx_rdy) begin
                state_d   = UNPACK;
                shreg_d   = pend_vld_q ? pend_q : rx_data;
                bit_cnt_d = 3'd0;
            end
            UNPACK: begin
                shreg_d   = shreg_q >> 1;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (last_bit) begin
                    if (last_byte) state_d = START;
                    else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = consume ? UNPACK : IDLE;
                        if (consume) shreg_d = pend_q;
                    end
                end
            end
            START: begin
                byte_cnt_d = '0;
                state_d    = WAIT_DONE;
            end
            WAIT_DONE: if (snn_done) begin
                digit_d = digit;
                state_d = TX;
            end
            TX: if (!tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (consume) pend_vld_d = 1'b0;
        if (store) begin
            if (!pend_vld_q || consume) begin
                pend_d     = rx_data;
                pend_vld_d = 1'b1;
            end else overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            overrun_q  <= 1'b0;
            digit_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            overrun_q  <= overrun_d;
            digit_q    <= digit_d;
        end
    end

    assign ram_we    = state_q == UNPACK;
    assign ram_addr  = ram_we ? {byte_cnt_q, bit_cnt_q} : core_addr;
    assign ram_d     = ram_we & shreg_q[0];
    assign snn_start = state_q == START;
    assign tx_start  = state_q == TX && !tx_busy;
    assign tx_data   = digit_q <= 4'd9 ? 8'h30 + {4'b0, digit_q} : 8'h3F;
    assign led       = {4'b0, digit_q};
    assign busy      = state_q != IDLE;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_snn_ctrl.sv
// tb_snn_ctrl: scoreboard bench; stimulus queues expected RAM writes, core starts and
// UART transmits, and a negedge monitor pops and compares them as the DUT emits them.
module tb_snn_ctrl;
    localparam int K_WR = 0, K_ST = 1, K_TX = 2;

    typedef struct {
        int         kind;
        int         addr;
        logic [7:0] val;
    } exp_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       rx_rdy = 1'b0, tx_busy = 1'b0, snn_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [9:0] core_addr = 10'h155;
    logic [3:0] digit = 4'd0;
    logic       tx_start, ram_we, ram_d, snn_start, busy, overrun;
    logic [7:0] tx_data, led;
    logic [9:0] ram_addr;

    exp_t q[$];
    int   checks = 0, errors = 0;
    int   start_cnt = 0, wr_run = 0, last_run = 0;
    logic prev783 = 1'b0;

    snn_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_d(ram_d), .core_addr(core_addr), .snn_start(snn_start), .snn_done(snn_done),
        .digit(digit), .led(led), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic pop_check(input int kind, input int addr, input logic [7:0] val);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d addr %0d val %0h, expected none", kind, addr, val);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            if (e.kind == K_WR && kind == K_WR) begin
                chk("wr_addr", addr, e.addr);
                chk("wr_data", {24'b0, val}, {24'b0, e.val});
            end
            if (e.kind == K_TX && kind == K_TX) chk("tx_data", {24'b0, val}, {24'b0, e.val});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ram_we) begin
                wr_run++;
                pop_check(K_WR, int'(ram_addr), {7'b0, ram_d});
            end else if (wr_run != 0) begin
                last_run = wr_run;
                wr_run = 0;
            end
            if (snn_start) begin
                start_cnt++;
                chk("start_after_783", {31'b0, prev783}, 1);
                pop_check(K_ST, 0, 8'h00);
            end
            if (tx_start) pop_check(K_TX, 0, tx_data);
            prev783 = ram_we && ram_addr == 10'd783;
        end else begin
            wr_run = 0;
            prev783 = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input int idx, input logic [7:0] b, input int nbits);
        for (int k = 0; k < nbits; k++) q.push_back('{K_WR, idx * 8 + k, {7'b0, b[k]}});
    endtask

    task automatic send_byte(input int idx, input logic [7:0] b, input int gap);
        push_byte(idx, b, 8);
        if (idx == 97) q.push_back('{K_ST, 0, 8'h00});
        rx_data = b;
        rx_rdy = 1'b1;
        tick;
        rx_rdy = 1'b0;
        repeat (8 + gap) tick;
    endtask

    function automatic logic [7:0] pat(input int kind, input int i);
        return kind == 0 ? 8'hA5 : kind == 1 ? 8'(i * 29 + 7) : 8'(i ^ 8'h6C);
    endfunction

    task automatic load_image(input int kind, input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(i, pat(kind, i), i % 3);
    endtask

    task automatic wait_start(input int s0);
        int n = 0;
        while (start_cnt == s0 && n < 60) begin
            tick;
            n++;
        end
        chk("snn_start_seen", start_cnt - s0, 1);
    endtask

    initial begin
        int s0;
        logic seen;
        repeat (3) tick;
        @(negedge clk);
        chk("rst_ram_addr", {22'b0, ram_addr}, 32'h155);
        chk("rst_ram_we", {31'b0, ram_we}, 0);
        chk("rst_ram_d", {31'b0, ram_d}, 0);
        chk("rst_tx_start", {31'b0, tx_start}, 0);
        chk("rst_snn_start", {31'b0, snn_start}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_overrun", {31'b0, overrun}, 0);
        chk("rst_led", {24'b0, led}, 0);
        chk("rst_tx_data", {24'b0, tx_data}, 32'h30);
        tick;
        rst_n = 1'b1;
        tick;
        // Image of 0xA5 bytes, digit 7 with the transmitter idle.
        s0 = start_cnt;
        load_image(0, 0, 97);
        wait_start(s0);
        q.push_back('{K_TX, 0, 8'h37});
        digit = 4'd7;
        snn_done = 1'b1;
        tick;
        snn_done = 1'b0;
        @(negedge clk);
        chk("tx_start_after_done", {31'b0, tx_start}, 1);
        chk("led_digit7", {24'b0, led}, 32'h07);
        tick;
        @(negedge clk);
        chk("busy_after_tx", {31'b0, busy}, 0);
        digit = 4'd9;
        snn_done = 1'b1;
        tick;
        snn_done = 1'b0;
        @(negedge clk);
        chk("done_ignored_idle", {24'b0, led}, 32'h07);
        // Varied image, digit 12 while the transmitter stays busy for 50 cycles.
        s0 = start_cnt;
        load_image(1, 0, 97);
        wait_start(s0);
        q.push_back('{K_TX, 0, 8'h3F});
        tx_busy = 1'b1;
        digit = 4'd12;
        snn_done = 1'b1;
        tick;
        snn_done = 1'b0;
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (tx_start) seen = 1'b1;
        end
        chk("no_tx_while_busy", {31'b0, seen}, 0);
        chk("led_digit12", {24'b0, led}, 32'h0C);
        chk("tx_data_held", {24'b0, tx_data}, 32'h3F);
        tick;
        tx_busy = 1'b0;
        @(negedge clk);
        chk("tx_after_busy_fall", {31'b0, tx_start}, 1);
        tick;
        tick;
        // Back-to-back bytes: second goes pending, third overflows.
        push_byte(0, 8'h3C, 8);
        push_byte(1, 8'hC3, 8);
        rx_data = 8'h3C; rx_rdy = 1'b1; tick; rx_rdy = 1'b0; tick;
        rx_data = 8'hC3; rx_rdy = 1'b1; tick; rx_rdy = 1'b0; tick;
        rx_data = 8'hFF; rx_rdy = 1'b1; tick; rx_rdy = 1'b0;
        repeat (20) tick;
        chk("b2b_run_len", last_run, 16);
        chk("overrun_set", {31'b0, overrun}, 1);
        chk("b2b_idle", {31'b0, busy}, 0);
        rst_n = 1'b0;
        tick;
        tick;
        @(negedge clk);
        chk("overrun_cleared", {31'b0, overrun}, 0);
        chk("rst_led2", {24'b0, led}, 0);
        tick;
        rst_n = 1'b1;
        tick;
        // 40 bytes, then a reset three bits into byte 40.
        load_image(2, 0, 39);
        push_byte(40, 8'h5A, 3);
        rx_data = 8'h5A; rx_rdy = 1'b1; tick; rx_rdy = 1'b0;
        tick;
        tick;
        tick;
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_no_write", {31'b0, ram_we}, 0);
        chk("abort_queue_drained", q.size(), 0);
        tick;
        rst_n = 1'b1;
        tick;
        s0 = start_cnt;
        load_image(2, 0, 97);
        wait_start(s0);
        q.push_back('{K_TX, 0, 8'h33});
        digit = 4'd3;
        snn_done = 1'b1;
        tick;
        snn_done = 1'b0;
        repeat (10) tick;
        chk("single_start", start_cnt - s0, 1);
        chk("led_digit3", {24'b0, led}, 32'h03);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/snn_ctrl.md
# snn_ctrl

Top-level sequencer for the digit-recognition SNN. It takes a 784-pixel binary image from the UART receiver as 98 bytes and unpacks it into the 1-bit input-unit RAM. It then starts the SNN core and waits for completion. Finally it latches the classified digit, shows it on the LEDs and sends its ASCII code back through the UART transmitter. It owns the input-unit RAM port and multiplexes its address between the loader and the core.

## Interface
- NUM_BYTES, 98, bytes per image (NUM_BYTES*8 = 784 input units)
- ADDR_W, 10, input-unit RAM address width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rx_rdy  in  1  one-cycle pulse: rx_data valid this cycle
- rx_data  in  8  received byte, pixel bits LSB-first
- tx_busy  in  1  UART transmitter busy
- tx_start  out  1  one-cycle pulse: transmit tx_data
- tx_data  out  8  ASCII digit to transmit
- ram_we  out  1  input-unit RAM write enable
- ram_addr  out  ADDR_W  input-unit RAM address
- ram_d  out  1  input-unit RAM write data
- core_addr  in  ADDR_W  input-unit address requested by the SNN core
- snn_start  out  1  one-cycle pulse: start the SNN core
- snn_done  in  1  one-cycle pulse from core: digit valid
- digit  in  4  core classification result
- led  out  8  {4'b0, latched digit}
- busy  out  1  high in every state except IDLE
- overrun  out  1  sticky: byte lost; cleared only by reset

## Operation
- States: IDLE, UNPACK, START, WAIT_DONE, TX.
- IDLE: on rx_rdy, load rx_data into the shift register and enter UNPACK. bit_cnt=0.
- UNPACK: one bit per cycle for 8 cycles.
  - ram_we=1, ram_d=shreg[0], ram_addr=byte_cnt*8+bit_cnt. Then shreg>>=1 and bit_cnt++.
  - After bit 7:
    - If byte_cnt==NUM_BYTES-1, go to START.
    - Otherwise go to IDLE with byte_cnt++.
    - If a pending byte is held, skip IDLE: enter UNPACK again directly with the pending byte.
- Pending buffer: one entry.
  - An rx_rdy during UNPACK/START/WAIT_DONE/TX is stored in the pending buffer if it is empty.
  - If it is full, the byte is dropped and overrun is set.
  - A pending byte is consumed only when the controller is in or returns to the load phase (from UNPACK or IDLE).
  - After the last image byte, bytes received before TX completes stay pending and form byte 0 of the next image.
- START: snn_start=1 for exactly one cycle. byte_cnt cleared. Go to WAIT_DONE.
- WAIT_DONE: on snn_done, latch digit into the digit register and go to TX.
- TX: when tx_busy==0, pulse tx_start for one cycle and go to IDLE.
  - tx_data = 8'h30+digit_reg when digit_reg<=9, else 8'h3F ('?').
  - tx_data is held stable from TX entry until tx_start plus one cycle.
- Address mux: ram_addr=core_addr whenever the state is not UNPACK. ram_we=0 outside UNPACK.
- led updates only on the snn_done latch.

## Timing
- Reset values: state IDLE; all counters 0; pending empty; tx_start, snn_start, ram_we, ram_d, overrun, busy = 0; led=0; digit_reg=0; tx_data=8'h30.
- rx_rdy to first RAM write: 1 cycle (write in the first UNPACK cycle).
- Byte load: exactly 8 consecutive write cycles, addresses strictly increasing by 1.
- Last write (addr 783) to snn_start: snn_start is asserted in the cycle immediately after it.
- snn_done to tx_start: 1 cycle if tx_busy=0, otherwise the cycle after tx_busy falls.
- snn_done outside WAIT_DONE is ignored.
- rx_rdy and pending consumption in the same cycle: the new byte goes to pending and no overrun is flagged.
- Reset mid-operation aborts immediately:
  - No further writes.
  - The partially loaded image is discarded; the next image starts at addr 0.

## Test plan
- Reset: all outputs at reset values. ram_addr follows core_addr=10'h155.
- Load 98 bytes 8'hA5 with gaps: ram writes to addrs 0..783 with data pattern 1,0,1,0,0,1,0,1 per byte. snn_start is exactly one pulse, one cycle after the addr-783 write.
- snn_done with digit=7 and tx_busy=0: led=8'h07, tx_start one cycle later, tx_data=8'h37, busy low afterwards.
- tx_busy held high 50 cycles after done with digit=12: tx_start fires the cycle after tx_busy falls, tx_data=8'h3F.
- Back-to-back rx_rdy 2 cycles apart: second byte is pending and unpacked with no idle gap (16 consecutive writes). A third byte within the same window sets overrun=1.
- Reset asserted after 40 bytes, then a full image: writes restart at addr 0, exactly one snn_start.
